// File: rtl/wired_param_inorder_iq.sv
// wired_param_inorder_iq: in-order issue queue for single-issue functional units.
// Micro-ops wait in a circular FIFO. Missing operands are captured by snooping
// the CDB ports. Only the oldest entry issues, and it lands in a registered
// output stage. Results return through a response FIFO toward the CDB arbiter.
// Optional feature macro: WIRED_IQ_BYPASS_EN (dispatch straight into the output
// register when the queue is empty and the op is fully ready).
module wired_param_inorder_iq #(
  parameter int IQ_DEPTH        = 4,
  parameter int SRC_CNT         = 2,
  parameter int CDB_CNT         = 2,
  parameter int RID_W           = 6,
  parameter int DATA_W          = 32,
  parameter int PAYLOAD_W       = 64,
  parameter int RESP_DEPTH      = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_i,
  input  logic                          p_valid_i,
  output logic                          p_ready_o,
  input  logic [PAYLOAD_W-1:0]          p_payload_i,
  input  logic [RID_W-1:0]              p_rid_i,
  input  logic [SRC_CNT-1:0]            p_src_rdy_i,
  input  logic [SRC_CNT*RID_W-1:0]      p_src_rid_i,
  input  logic [SRC_CNT*DATA_W-1:0]     p_src_data_i,
  input  logic [CDB_CNT-1:0]            cdb_valid_i,
  input  logic [CDB_CNT*RID_W-1:0]      cdb_rid_i,
  input  logic [CDB_CNT*DATA_W-1:0]     cdb_data_i,
  output logic                          ex_valid_o,
  input  logic                          ex_ready_i,
  output logic [PAYLOAD_W-1:0]          ex_payload_o,
  output logic [RID_W-1:0]              ex_rid_o,
  output logic [SRC_CNT*DATA_W-1:0]     ex_src_o,
  input  logic                          ex_resp_valid_i,
  output logic                          ex_resp_ready_o,
  input  logic [RID_W-1:0]              ex_resp_rid_i,
  input  logic [DATA_W-1:0]             ex_resp_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [RID_W-1:0]              out_rid_o,
  output logic [DATA_W-1:0]             out_data_o,
  output logic [$clog2(IQ_DEPTH):0]     occupancy_o
);

  localparam int PTR_W  = $clog2(IQ_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int RPTR_W = $clog2(RESP_DEPTH);
  localparam int RCNT_W = RPTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(IQ_DEPTH);
  localparam logic [RCNT_W-1:0] RDEPTH_C = RCNT_W'(RESP_DEPTH);
  localparam logic [RCNT_W-1:0] MAXOUT_C = RCNT_W'(MAX_OUTSTANDING);

  // Queue storage and pointers
  logic [PAYLOAD_W-1:0]      pay_q   [IQ_DEPTH];
  logic [PAYLOAD_W-1:0]      pay_d   [IQ_DEPTH];
  logic [RID_W-1:0]          rid_q   [IQ_DEPTH];
  logic [RID_W-1:0]          rid_d   [IQ_DEPTH];
  logic [SRC_CNT-1:0]        rdy_q   [IQ_DEPTH];
  logic [SRC_CNT-1:0]        rdy_d   [IQ_DEPTH];
  logic [SRC_CNT*RID_W-1:0]  srid_q  [IQ_DEPTH];
  logic [SRC_CNT*RID_W-1:0]  srid_d  [IQ_DEPTH];
  logic [SRC_CNT*DATA_W-1:0] sdata_q [IQ_DEPTH];
  logic [SRC_CNT*DATA_W-1:0] sdata_d [IQ_DEPTH];
  logic [PTR_W-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]          count_q, count_d;

  // Output register toward the execution unit
  logic                      ex_valid_q, ex_valid_d;
  logic [PAYLOAD_W-1:0]      ex_payload_q, ex_payload_d;
  logic [RID_W-1:0]          ex_rid_q, ex_rid_d;
  logic [SRC_CNT*DATA_W-1:0] ex_src_q, ex_src_d;

  // Response FIFO and credit counter
  logic [RID_W-1:0]          rrid_q  [RESP_DEPTH];
  logic [RID_W-1:0]          rrid_d  [RESP_DEPTH];
  logic [DATA_W-1:0]         rdata_q [RESP_DEPTH];
  logic [DATA_W-1:0]         rdata_d [RESP_DEPTH];
  logic [RPTR_W-1:0]         rwr_q, rwr_d, rrd_q, rrd_d;
  logic [RCNT_W-1:0]         rcnt_q, rcnt_d;
  logic [RCNT_W-1:0]         outst_q, outst_d;

  logic [SRC_CNT-1:0]        in_rdy;
  logic [SRC_CNT*DATA_W-1:0] in_data;
  logic enq, enq_queue, bypass, issue, out_free, credit_ok;
  logic ex_hs, resp_push, resp_pop;

  assign p_ready_o       = count_q < DEPTH_C;
  assign enq             = p_valid_i && p_ready_o;
  assign out_free        = !ex_valid_q || ex_ready_i;
  // The op sitting in the output register counts against the limit as well, so
  // issued-but-not-drained ops never exceed MAX_OUTSTANDING and the response
  // FIFO can always absorb every result.
  assign credit_ok       = (outst_q + RCNT_W'(ex_valid_q)) < MAXOUT_C;
  assign issue           = (count_q != '0) && (&rdy_q[tail_q]) && out_free && credit_ok;
  assign enq_queue       = enq && !bypass;
  assign ex_hs           = ex_valid_q && ex_ready_i;
  assign ex_resp_ready_o = rcnt_q != RDEPTH_C;
  assign out_valid_o     = rcnt_q != '0;
  assign resp_push       = ex_resp_valid_i && ex_resp_ready_o;
  assign resp_pop        = out_valid_o && out_ready_i;

`ifdef WIRED_IQ_BYPASS_EN
  assign bypass = enq && (count_q == '0) && out_free && credit_ok && (&in_rdy);
`else
  assign bypass = 1'b0;
`endif

  assign ex_valid_o   = ex_valid_q;
  assign ex_payload_o = ex_payload_q;
  assign ex_rid_o     = ex_rid_q;
  assign ex_src_o     = ex_src_q;
  assign out_rid_o    = out_valid_o ? rrid_q[rrd_q] : '0;
  assign out_data_o   = out_valid_o ? rdata_q[rrd_q] : '0;
  assign occupancy_o  = count_q;

  // Incoming operands: not-ready ones pick up a same-cycle CDB match (lowest port wins)
  always_comb begin
    in_rdy  = p_src_rdy_i;
    in_data = p_src_data_i;
    for (int s = 0; s < SRC_CNT; s++) begin
      if (!p_src_rdy_i[s]) begin
        for (int c = CDB_CNT - 1; c >= 0; c--) begin
          if (cdb_valid_i[c] && (cdb_rid_i[c*RID_W +: RID_W] == p_src_rid_i[s*RID_W +: RID_W])) begin
            in_rdy[s]                  = 1'b1;
            in_data[s*DATA_W +: DATA_W] = cdb_data_i[c*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Queue next state: snoop every not-ready operand, then write the dispatched op at head
  always_comb begin
    pay_d   = pay_q;
    rid_d   = rid_q;
    rdy_d   = rdy_q;
    srid_d  = srid_q;
    sdata_d = sdata_q;
    for (int e = 0; e < IQ_DEPTH; e++) begin
      for (int s = 0; s < SRC_CNT; s++) begin
        if (!rdy_q[e][s]) begin
          for (int c = CDB_CNT - 1; c >= 0; c--) begin
            if (cdb_valid_i[c] && (cdb_rid_i[c*RID_W +: RID_W] == srid_q[e][s*RID_W +: RID_W])) begin
              rdy_d[e][s]                     = 1'b1;
              sdata_d[e][s*DATA_W +: DATA_W] = cdb_data_i[c*DATA_W +: DATA_W];
            end
          end
        end
      end
    end
    if (enq_queue) begin
      pay_d[head_q]   = p_payload_i;
      rid_d[head_q]   = p_rid_i;
      rdy_d[head_q]   = in_rdy;
      srid_d[head_q]  = p_src_rid_i;
      sdata_d[head_q] = in_data;
    end
    head_d  = head_q + PTR_W'(enq_queue);
    tail_d  = tail_q + PTR_W'(issue);
    count_d = count_q + CNT_W'(enq_queue) - CNT_W'(issue);
  end

  // Output register: load from the tail (or bypassed dispatch), clear once drained
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_payload_d = ex_payload_q;
    ex_rid_d     = ex_rid_q;
    ex_src_d     = ex_src_q;
    if (issue) begin
      ex_valid_d   = 1'b1;
      ex_payload_d = pay_q[tail_q];
      ex_rid_d     = rid_q[tail_q];
      ex_src_d     = sdata_q[tail_q];
    end else if (bypass) begin
      ex_valid_d   = 1'b1;
      ex_payload_d = p_payload_i;
      ex_rid_d     = p_rid_i;
      ex_src_d     = in_data;
    end else if (ex_hs) begin
      ex_valid_d   = 1'b0;
    end
    outst_d = outst_q + RCNT_W'(ex_hs) - RCNT_W'(resp_pop);
  end

  // Response FIFO next state; no fall-through, so a pushed result shows next cycle
  always_comb begin
    rrid_d  = rrid_q;
    rdata_d = rdata_q;
    if (resp_push) begin
      rrid_d[rwr_q]  = ex_resp_rid_i;
      rdata_d[rwr_q] = ex_resp_data_i;
    end
    rwr_d  = rwr_q + RPTR_W'(resp_push);
    rrd_d  = rrd_q + RPTR_W'(resp_pop);
    rcnt_d = rcnt_q + RCNT_W'(resp_push) - RCNT_W'(resp_pop);
  end

  // Control state: reset and flush both return everything to empty
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      ex_valid_q   <= 1'b0;
      ex_payload_q <= '0;
      ex_rid_q     <= '0;
      ex_src_q     <= '0;
      rwr_q        <= '0;
      rrd_q        <= '0;
      rcnt_q       <= '0;
      outst_q      <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      ex_valid_q   <= ex_valid_d;
      ex_payload_q <= ex_payload_d;
      ex_rid_q     <= ex_rid_d;
      ex_src_q     <= ex_src_d;
      rwr_q        <= rwr_d;
      rrd_q        <= rrd_d;
      rcnt_q       <= rcnt_d;
      outst_q      <= outst_d;
    end
  end

  // Entry storage needs no reset: occupancy decides which slots are meaningful
  always_ff @(posedge clk) begin
    pay_q   <= pay_d;
    rid_q   <= rid_d;
    rdy_q   <= rdy_d;
    srid_q  <= srid_d;
    sdata_q <= sdata_d;
    rrid_q  <= rrid_d;
    rdata_q <= rdata_d;
  end

endmodule

// File: tb/tb_wired_param_inorder_iq.sv
// Testbench for wired_param_inorder_iq: directed scenarios plus a randomized
// phase, checked by a scoreboard. Dispatch pushes the expected issue, and a
// negedge monitor pops it on every ex/out handshake.
module tb_wired_param_inorder_iq;

  localparam int IQ_DEPTH = 4, SRC_CNT = 2, CDB_CNT = 2, RID_W = 6, DATA_W = 32;
  localparam int PAYLOAD_W = 64, RESP_DEPTH = 16, MAX_OUTSTANDING = 2;
`ifdef WIRED_IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, flush_i = 1'b0;
  logic p_valid_i = 1'b0, p_ready_o;
  logic [PAYLOAD_W-1:0] p_payload_i = '0;
  logic [RID_W-1:0] p_rid_i = '0;
  logic [SRC_CNT-1:0] p_src_rdy_i = '0;
  logic [SRC_CNT*RID_W-1:0] p_src_rid_i = '0;
  logic [SRC_CNT*DATA_W-1:0] p_src_data_i = '0;
  logic [CDB_CNT-1:0] cdb_valid_i = '0;
  logic [CDB_CNT*RID_W-1:0] cdb_rid_i = '0;
  logic [CDB_CNT*DATA_W-1:0] cdb_data_i = '0;
  logic ex_valid_o, ex_ready_i = 1'b0;
  logic [PAYLOAD_W-1:0] ex_payload_o;
  logic [RID_W-1:0] ex_rid_o;
  logic [SRC_CNT*DATA_W-1:0] ex_src_o;
  logic ex_resp_valid_i = 1'b0, ex_resp_ready_o;
  logic [RID_W-1:0] ex_resp_rid_i = '0;
  logic [DATA_W-1:0] ex_resp_data_i = '0;
  logic out_valid_o, out_ready_i = 1'b0;
  logic [RID_W-1:0] out_rid_o;
  logic [DATA_W-1:0] out_data_o;
  logic [$clog2(IQ_DEPTH):0] occupancy_o;

  wired_param_inorder_iq #(
    .IQ_DEPTH(IQ_DEPTH), .SRC_CNT(SRC_CNT), .CDB_CNT(CDB_CNT), .RID_W(RID_W),
    .DATA_W(DATA_W), .PAYLOAD_W(PAYLOAD_W), .RESP_DEPTH(RESP_DEPTH),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .p_valid_i(p_valid_i), .p_ready_o(p_ready_o), .p_payload_i(p_payload_i),
    .p_rid_i(p_rid_i), .p_src_rdy_i(p_src_rdy_i), .p_src_rid_i(p_src_rid_i),
    .p_src_data_i(p_src_data_i), .cdb_valid_i(cdb_valid_i), .cdb_rid_i(cdb_rid_i),
    .cdb_data_i(cdb_data_i), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_payload_o(ex_payload_o), .ex_rid_o(ex_rid_o), .ex_src_o(ex_src_o),
    .ex_resp_valid_i(ex_resp_valid_i), .ex_resp_ready_o(ex_resp_ready_o),
    .ex_resp_rid_i(ex_resp_rid_i), .ex_resp_data_i(ex_resp_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_rid_o(out_rid_o),
    .out_data_o(out_data_o), .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pay;
    logic [5:0]  rid;
    logic [63:0] src;
  } exp_t;
  typedef struct {
    logic [5:0]  rid;
    logic [31:0] data;
  } out_t;

  exp_t exq[$];
  logic [5:0] euq[$];
  out_t outq[$];
  exp_t curOp;
  int errors = 0, checks = 0, accepts = 0, exHs = 0;
  bit euEn = 1'b0;
  logic [31:0] tagval [16];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one dispatch request and remember its expected issue contents
  task automatic applyStimulus(input logic [63:0] pay, input logic [5:0] rid, input logic [1:0] rdy,
                               input logic [11:0] srid, input logic [63:0] sdata, input logic [63:0] expSrc);
    p_valid_i = 1'b1; p_payload_i = pay; p_rid_i = rid; p_src_rdy_i = rdy;
    p_src_rid_i = srid; p_src_data_i = sdata;
    curOp.pay = pay; curOp.rid = rid; curOp.src = expSrc;
  endtask

  // One clock: sample handshakes at negedge, update model after the edge, act as the EU
  task automatic step();
    bit dAcc, rAcc;
    out_t o;
    @(negedge clk);
    dAcc = p_valid_i && p_ready_o && !flush_i && rst_n;
    rAcc = ex_resp_valid_i && ex_resp_ready_o && !flush_i && rst_n;
    o.rid = ex_resp_rid_i; o.data = ex_resp_data_i;
    @(posedge clk); #1;
    if (flush_i) begin
      exq.delete(); euq.delete(); outq.delete();
    end
    if (dAcc) begin exq.push_back(curOp); accepts++; end
    if (rAcc) begin outq.push_back(o); void'(euq.pop_front()); end
    p_valid_i = 1'b0; cdb_valid_i = '0; flush_i = 1'b0; ex_resp_valid_i = 1'b0;
    if (euEn && euq.size() > 0 && $urandom_range(0, 3) != 0) begin
      ex_resp_valid_i = 1'b1; ex_resp_rid_i = euq[0]; ex_resp_data_i = $urandom;
    end
  endtask

  task automatic sendReady(input logic [5:0] rid);
    logic [63:0] d;
    int a0, n;
    d = {$urandom, $urandom};
    a0 = accepts; n = 0;
    do begin
      applyStimulus({$urandom, $urandom}, rid, 2'b11, '0, d, d);
      step(); n++;
    end while (accepts == a0 && n < 50);
    checkOutput("dispatch_accepted", 64'(accepts - a0), 64'd1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    ex_ready_i = 1'b1; out_ready_i = 1'b1; euEn = 1'b1;
    while ((exq.size() != 0 || euq.size() != 0 || outq.size() != 0 || ex_valid_o || out_valid_o) && n < 400) begin
      step(); n++;
    end
    checkOutput({name, "_drain_pending"}, 64'(exq.size() + euq.size() + outq.size()), 64'd0);
    checkOutput({name, "_drain_occupancy"}, 64'(occupancy_o), 64'd0);
  endtask

  // Monitor: every handshake pops the oldest expected item and compares
  always @(negedge clk) begin
    exp_t e;
    out_t o;
    if (rst_n && !flush_i) begin
      if (ex_valid_o && ex_ready_i) begin
        exHs++;
        if (exq.size() == 0) begin
          checkOutput("ex_unexpected_issue", 64'(ex_rid_o), 64'hFFFF);
        end else begin
          e = exq.pop_front();
          checkOutput("ex_rid", 64'(ex_rid_o), 64'(e.rid));
          checkOutput("ex_payload", ex_payload_o, e.pay);
          checkOutput("ex_src", ex_src_o, e.src);
          euq.push_back(e.rid);
        end
      end
      if (out_valid_o && out_ready_i) begin
        if (outq.size() == 0) begin
          checkOutput("out_unexpected", 64'(out_rid_o), 64'hFFFF);
        end else begin
          o = outq.pop_front();
          checkOutput("out_rid", 64'(out_rid_o), 64'(o.rid));
          checkOutput("out_data", 64'(out_data_o), 64'(o.data));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a0, occ4, base, n, t;
    bit pend;
    logic [63:0] pPay, pData, pExp;
    logic [5:0] pRid;
    logic [1:0] pRdy;
    logic [11:0] pSrid;
    int seq;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    checkOutput("rst_p_ready", 64'(p_ready_o), 64'd1);
    checkOutput("rst_ex_valid", 64'(ex_valid_o), 64'd0);
    checkOutput("rst_resp_ready", 64'(ex_resp_ready_o), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid_o), 64'd0);
    checkOutput("rst_occupancy", 64'(occupancy_o), 64'd0);
    checkOutput("rst_ex_rid", 64'(ex_rid_o), 64'd0);
    checkOutput("rst_ex_payload", ex_payload_o, 64'd0);
    checkOutput("rst_ex_src", ex_src_o, 64'd0);
    checkOutput("rst_out_rid", 64'(out_rid_o), 64'd0);
    checkOutput("rst_out_data", 64'(out_data_o), 64'd0);

    // Latency of a fully ready op into an empty queue
    ex_ready_i = 1'b0; euEn = 1'b1; out_ready_i = 1'b1;
    pData = {$urandom, $urandom};
    applyStimulus(64'hCAFE_0001, 6'd20, 2'b11, '0, pData, pData);
    step();
    checkOutput("lat_ex_valid_T1", 64'(ex_valid_o), 64'(BYP));
    checkOutput("lat_occupancy_T1", 64'(occupancy_o), BYP ? 64'd0 : 64'd1);
    step();
    checkOutput("lat_ex_valid_T2", 64'(ex_valid_o), 64'd1);
    checkOutput("lat_occupancy_T2", 64'(occupancy_o), 64'd0);
    checkOutput("lat_ex_rid", 64'(ex_rid_o), 64'd20);
    drain("latency");

    // Fill: five ready ops with the EU stalled
    ex_ready_i = 1'b0; a0 = accepts; occ4 = -1;
    for (int k = 0; k < 8; k++) begin
      pData = {$urandom, $urandom};
      applyStimulus({32'h0, 32'(k)}, 6'(40 + accepts - a0), 2'b11, '0, pData, pData);
      step();
      if (accepts - a0 == 4 && occ4 < 0) occ4 = int'(occupancy_o);
    end
    checkOutput("fill_accepts", 64'(accepts - a0), 64'd5);
    checkOutput("fill_occ_after_4", 64'(occ4), 64'd3);
    checkOutput("fill_occupancy", 64'(occupancy_o), 64'd4);
    checkOutput("fill_p_ready", 64'(p_ready_o), 64'd0);
    checkOutput("fill_ex_rid_held", 64'(ex_rid_o), 64'd40);
    drain("fill");

    // In-order wakeup: unready head blocks a ready younger op
    ex_ready_i = 1'b0;
    applyStimulus(64'hA, 6'd30, 2'b10, {6'd0, 6'd5}, {32'h1234, 32'h0BAD}, {32'h1234, 32'hDEAD});
    step();
    sendReady(6'd31);
    repeat (3) step();
    checkOutput("wake_blocked_ex_valid", 64'(ex_valid_o), 64'd0);
    checkOutput("wake_blocked_occ", 64'(occupancy_o), 64'd2);
    cdb_valid_i = 2'b11; cdb_rid_i = {6'd5, 6'd6}; cdb_data_i = {32'hDEAD, 32'hBAD0};
    step();
    checkOutput("wake_T1_ex_valid", 64'(ex_valid_o), 64'd0);
    step();
    checkOutput("wake_T2_ex_valid", 64'(ex_valid_o), 64'd1);
    checkOutput("wake_T2_src0", 64'(ex_src_o[31:0]), 64'hDEAD);
    checkOutput("wake_T2_rid", 64'(ex_rid_o), 64'd30);
    drain("wakeup");

    // Both CDB ports match in the enqueue cycle: port 0 wins
    ex_ready_i = 1'b1; a0 = accepts;
    applyStimulus(64'hB, 6'd33, 2'b10, {6'd0, 6'd7}, {32'h5555, 32'h0}, {32'h5555, 32'h11});
    cdb_valid_i = 2'b11; cdb_rid_i = {6'd7, 6'd7}; cdb_data_i = {32'h22, 32'h11};
    step();
    checkOutput("dualcdb_accepted", 64'(accepts - a0), 64'd1);
    drain("dualcdb");

    // Credit limit with no results returning
    ex_ready_i = 1'b1; euEn = 1'b0; out_ready_i = 1'b0; base = exHs;
    for (int k = 0; k < 4; k++) sendReady(6'(34 + k));
    repeat (8) step();
    checkOutput("credit_stall", 64'(exHs - base), 64'd2);
    euEn = 1'b1;
    repeat (6) step();
    checkOutput("credit_resp_in_fifo", 64'(exHs - base), 64'd2);
    checkOutput("credit_out_valid", 64'(out_valid_o), 64'd1);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    repeat (6) step();
    checkOutput("credit_one_more", 64'(exHs - base), 64'd3);
    drain("credit");

    // Flush with work everywhere
    out_ready_i = 1'b0; euEn = 1'b1; ex_ready_i = 1'b1;
    sendReady(6'd50);
    n = 0;
    while (!out_valid_o && n < 20) begin step(); n++; end
    ex_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) sendReady(6'(51 + k));
    repeat (2) step();
    checkOutput("preflush_occ", 64'(occupancy_o), 64'd3);
    checkOutput("preflush_ex_valid", 64'(ex_valid_o), 64'd1);
    checkOutput("preflush_out_valid", 64'(out_valid_o), 64'd1);
    flush_i = 1'b1;
    applyStimulus(64'hF, 6'd60, 2'b11, '0, 64'h1, 64'h1);
    cdb_valid_i = 2'b01; cdb_rid_i = {6'd0, 6'd1}; cdb_data_i = '1;
    step();
    checkOutput("flush_ex_valid", 64'(ex_valid_o), 64'd0);
    checkOutput("flush_out_valid", 64'(out_valid_o), 64'd0);
    checkOutput("flush_occ", 64'(occupancy_o), 64'd0);
    checkOutput("flush_p_ready", 64'(p_ready_o), 64'd1);
    checkOutput("flush_resp_ready", 64'(ex_resp_ready_o), 64'd1);

    // Random traffic against the scoreboard, exercising pointer wrap
    for (int i = 0; i < 16; i++) tagval[i] = $urandom;
    pend = 1'b0; seq = 0;
    pPay = '0; pData = '0; pExp = '0; pRid = '0; pRdy = '0; pSrid = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend = 1'b1;
        pPay = {$urandom, $urandom};
        pRid = 6'(32 + (seq % 32)); seq++;
        pData = {$urandom, $urandom};
        for (int s = 0; s < 2; s++) begin
          pRdy[s] = 1'($urandom_range(0, 1));
          t = $urandom_range(0, 15);
          pSrid[s*6 +: 6] = 6'(t);
          pExp[s*32 +: 32] = pRdy[s] ? pData[s*32 +: 32] : tagval[t];
        end
      end
      if (pend) applyStimulus(pPay, pRid, pRdy, pSrid, pData, pExp);
      for (int c = 0; c < 2; c++) begin
        t = $urandom_range(0, 15);
        cdb_valid_i[c] = ($urandom_range(0, 2) == 0);
        cdb_rid_i[c*6 +: 6] = 6'(t);
        cdb_data_i[c*32 +: 32] = tagval[t];
      end
      ex_ready_i = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      a0 = accepts;
      step();
      if (accepts != a0) pend = 1'b0;
    end
    checkOutput("random_dispatched_enough", 64'(seq > 40), 64'd1);
    // Let any still-waiting operand see its tag
    for (int k = 0; k < 40; k++) begin
      t = k % 16;
      cdb_valid_i = 2'b01; cdb_rid_i = {6'd0, 6'(t)}; cdb_data_i = {32'h0, tagval[t]};
      ex_ready_i = 1'b1; out_ready_i = 1'b1;
      step();
    end
    drain("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
